// File: rtl/drain_pkg.sv
// Shared types and helpers for the PE result-memory drain engine.
// Holds the controller state encoding and the per-PE word slice of the c bus.
package drain_pkg;

   localparam int WORD_W = 32;
   localparam int MAX_PE = 64;
   localparam int EXT_W  = WORD_W * MAX_PE;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_ALL = 3'd1,
      REQ      = 3'd2,
      CAPTURE  = 3'd3,
      PRESENT  = 3'd4,
      DONE     = 3'd5
   } drain_state_e;

   // The c bus is zero-extended to MAX_PE slots so one helper serves every NUM_PE.
   function automatic logic [WORD_W-1:0] pe_slot(input logic [EXT_W-1:0] bus, input logic [5:0] idx);
      pe_slot = bus[int'(idx)*WORD_W +: WORD_W];
   endfunction

endpackage

// File: rtl/drain_index_counter.sv
// Nested (pe, address) walk counter for the result drain.
// p_succ/a_succ expose the successor index so the next request can be registered in advance.
module drain_index_counter #(
   parameter int LOG_SIZE = 3,
   parameter int NUM_PE   = 4,
   parameter int PE_W     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                inc,
   output logic [PE_W-1:0]     p,
   output logic [LOG_SIZE-1:0] a,
   output logic [PE_W-1:0]     p_succ,
   output logic [LOG_SIZE-1:0] a_succ,
   output logic                is_last
);
   import drain_pkg::*;

   localparam logic [PE_W-1:0]     P_MAX = PE_W'(NUM_PE - 1);
   localparam logic [LOG_SIZE-1:0] A_MAX = {LOG_SIZE{1'b1}};

   // Successor index: address wraps naturally, PE advances on address wrap.
   always_comb begin
      a_succ = a + LOG_SIZE'(1);
      p_succ = p;
      if (a == A_MAX) begin
         if (p == P_MAX) begin
            p_succ = {PE_W{1'b0}};
         end else begin
            p_succ = p + PE_W'(1);
         end
      end else begin
         p_succ = p;
      end
      is_last = (p == P_MAX) && (a == A_MAX);
   end

   // Index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p <= {PE_W{1'b0}};
         a <= {LOG_SIZE{1'b0}};
      end else if (clear) begin
         p <= {PE_W{1'b0}};
         a <= {LOG_SIZE{1'b0}};
      end else if (inc) begin
         p <= p_succ;
         a <= a_succ;
      end else begin
         p <= p;
         a <= a;
      end
   end

endmodule

// File: rtl/pe_result_drain.sv
// Reader end of the PE result-memory port: once every PE signals output_stb it walks
// each PE accumulator memory in order and streams the words out on a stb/ack port.
module pe_result_drain
   import drain_pkg::*;
#(
   parameter  int LOG_SIZE = 3,
   parameter  int NUM_PE   = 4,
   localparam int PE_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [NUM_PE-1:0]        pe_done,
   input  logic [WORD_W*NUM_PE-1:0] pe_c,
   output logic [LOG_SIZE-1:0]      pe_addr,
   output logic [NUM_PE-1:0]        pe_mem_sel,
   output logic [WORD_W-1:0]        out_data,
   output logic [PE_W-1:0]          out_pe,
   output logic [LOG_SIZE-1:0]      out_addr,
   output logic                     out_last,
   output logic                     out_stb,
   input  logic                     out_ack,
   output logic                     busy,
   output logic                     done
);

   drain_state_e          state_r;
   logic [PE_W-1:0]       p_s;
   logic [LOG_SIZE-1:0]   a_s;
   logic [PE_W-1:0]       p_succ_s;
   logic [LOG_SIZE-1:0]   a_succ_s;
   logic                  is_last_s;
   logic                  clear_s;
   logic                  inc_s;
   logic [EXT_W-1:0]      c_ext_s;

   assign c_ext_s = EXT_W'(pe_c);

   drain_index_counter #(
      .LOG_SIZE (LOG_SIZE),
      .NUM_PE   (NUM_PE),
      .PE_W     (PE_W)
   ) u_index (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear_s),
      .inc     (inc_s),
      .p       (p_s),
      .a       (a_s),
      .p_succ  (p_succ_s),
      .a_succ  (a_succ_s),
      .is_last (is_last_s)
   );

   // Index control: restart on accepted start, step when a non-final word is taken.
   always_comb begin
      clear_s = 1'b0;
      inc_s   = 1'b0;
      if (state_r == IDLE) begin
         clear_s = start;
      end else begin
         clear_s = 1'b0;
      end
      if (state_r == PRESENT) begin
         inc_s = out_ack && !out_last;
      end else begin
         inc_s = 1'b0;
      end
   end

   // Controller and registered outputs; the memory select is set one edge ahead so it is high during REQ.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         pe_addr    <= {LOG_SIZE{1'b0}};
         pe_mem_sel <= {NUM_PE{1'b0}};
         out_data   <= {WORD_W{1'b0}};
         out_pe     <= {PE_W{1'b0}};
         out_addr   <= {LOG_SIZE{1'b0}};
         out_last   <= 1'b0;
         out_stb    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= WAIT_ALL;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            WAIT_ALL: begin
               if (&pe_done) begin
                  state_r    <= REQ;
                  pe_mem_sel <= NUM_PE'(1) << p_s;
                  pe_addr    <= a_s;
               end
            end
            REQ: begin
               state_r    <= CAPTURE;
               pe_mem_sel <= {NUM_PE{1'b0}};
            end
            CAPTURE: begin
               state_r  <= PRESENT;
               out_data <= pe_slot(c_ext_s, 6'(p_s));
               out_pe   <= p_s;
               out_addr <= a_s;
               out_last <= is_last_s;
               out_stb  <= 1'b1;
            end
            PRESENT: begin
               if (out_ack) begin
                  out_stb  <= 1'b0;
                  out_last <= 1'b0;
                  if (out_last) begin
                     state_r <= DONE;
                  end else begin
                     state_r    <= REQ;
                     pe_mem_sel <= NUM_PE'(1) << p_succ_s;
                     pe_addr    <= a_succ_s;
                  end
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            default: begin
               state_r    <= IDLE;
               pe_mem_sel <= {NUM_PE{1'b0}};
               out_stb    <= 1'b0;
               out_last   <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed self-checking bench for pe_result_drain with NUM_PE=2, LOG_SIZE=2.
// A small PE model holds word p*16+a in each memory and registers c while its select is high.
module tb_pe_result_drain;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  pe_done = 2'b00;
   logic [63:0] pe_c;
   logic [1:0]  pe_addr;
   logic [1:0]  pe_mem_sel;
   logic [31:0] out_data;
   logic [0:0]  out_pe;
   logic [1:0]  out_addr;
   logic        out_last;
   logic        out_stb;
   logic        out_ack = 1'b1;
   logic        busy;
   logic        done;

   logic [31:0] c_q [2];
   int passed = 0;
   int total = 0;
   int failed = 0;
   int cyc = 0;
   int sel_cnt = 0;
   int oh_err = 0;
   logic [1:0] last_sel_addr = 2'b00;
   int stb_cyc [8];
   int start_cyc = 0;
   int sel_base = 0;

   assign pe_c = {c_q[1], c_q[0]};

   pe_result_drain #(.LOG_SIZE(2), .NUM_PE(2)) dut (
      .clk(clk), .rst(rst), .start(start), .pe_done(pe_done), .pe_c(pe_c),
      .pe_addr(pe_addr), .pe_mem_sel(pe_mem_sel), .out_data(out_data), .out_pe(out_pe),
      .out_addr(out_addr), .out_last(out_last), .out_stb(out_stb), .out_ack(out_ack),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // PE memory model: c is registered on the edge that closes a selected cycle.
   initial begin
      c_q[0] = 32'h0;
      c_q[1] = 32'h0;
   end
   always @(posedge clk) begin
      if (pe_mem_sel[0]) c_q[0] <= 32'h00 + 32'(pe_addr);
      if (pe_mem_sel[1]) c_q[1] <= 32'h10 + 32'(pe_addr);
      cyc <= cyc + 1;
   end

   // Select monitor: counts select cycles and one-hot violations.
   always @(negedge clk) begin
      if (!rst) begin
         if (pe_mem_sel != 2'b00) begin
            sel_cnt = sel_cnt + 1;
            last_sel_addr = pe_addr;
         end
         if (!$onehot0(pe_mem_sel)) oh_err = oh_err + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      start_cyc = cyc;
   endtask

   // Collect the 8-word stream; optional stall word, stray start word and abort word.
   task automatic collect(input int stall_idx, input int stray_idx, input int abort_idx);
      for (int w = 0; w < 8; w++) begin
         logic [31:0] exp_data;
         int guard;
         exp_data = 32'((w / 4) * 16 + (w % 4));
         guard = 0;
         while (!out_stb && guard < 40) begin
            tick();
            guard++;
         end
         chk($sformatf("stb_w%0d", w), 32'(out_stb), 32'd1);
         stb_cyc[w] = cyc;
         chk($sformatf("data_w%0d", w), out_data, exp_data);
         chk($sformatf("pe_w%0d", w), 32'(out_pe), 32'(w / 4));
         chk($sformatf("addr_w%0d", w), 32'(out_addr), 32'(w % 4));
         chk($sformatf("last_w%0d", w), 32'(out_last), 32'(w == 7));
         chk($sformatf("seladdr_w%0d", w), 32'(last_sel_addr), 32'(w % 4));
         if (w == abort_idx) return;
         if (w == stall_idx) begin
            for (int s = 0; s < 5; s++) begin
               tick();
               chk("stall_stb", 32'(out_stb), 32'd1);
               chk("stall_data", out_data, exp_data);
               chk("stall_addr", 32'(out_addr), 32'(w % 4));
               chk("stall_pe", 32'(out_pe), 32'(w / 4));
               chk("stall_sel", 32'(pe_mem_sel), 32'd0);
            end
            out_ack = 1'b1;
         end
         if (w == stray_idx) start = 1'b1;
         tick();
         start = 1'b0;
         chk($sformatf("stb_clr_w%0d", w), 32'(out_stb), 32'd0);
         if (w + 1 == stall_idx) out_ack = 1'b0;
      end
   endtask

   task automatic check_finish();
      chk("done_dly", 32'(done), 32'd0);
      chk("busy_dly", 32'(busy), 32'd1);
      tick();
      chk("done_set", 32'(done), 32'd1);
      chk("busy_clr", 32'(busy), 32'd0);
      chk("sel_count", 32'(sel_cnt - sel_base), 32'd8);
      chk("onehot", 32'(oh_err), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_sel", 32'(pe_mem_sel), 32'd0);
      chk("rst_stb", 32'(out_stb), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_data", out_data, 32'd0);
      rst = 1'b0;
      tick();

      // Basic drain, ack always high
      pe_done = 2'b11;
      sel_base = sel_cnt;
      pulse_start();
      chk("busy_start", 32'(busy), 32'd1);
      collect(-1, -1, -1);
      chk("first_lat", 32'(stb_cyc[0] - start_cyc), 32'd3);
      chk("period_1", 32'(stb_cyc[1] - stb_cyc[0]), 32'd3);
      chk("period_7", 32'(stb_cyc[7] - stb_cyc[6]), 32'd3);
      check_finish();

      // Wait for all PEs
      pe_done = 2'b01;
      sel_base = sel_cnt;
      pulse_start();
      chk("done_clr_on_start", 32'(done), 32'd0);
      repeat (10) tick();
      chk("wait_no_sel", 32'(sel_cnt - sel_base), 32'd0);
      chk("wait_no_stb", 32'(out_stb), 32'd0);
      pe_done = 2'b11;
      tick();
      chk("wait_req_sel", 32'(pe_mem_sel), 32'd1);
      chk("wait_req_addr", 32'(pe_addr), 32'd0);
      collect(-1, -1, -1);
      check_finish();

      // Backpressure on word 2 plus a stray start mid-drain
      sel_base = sel_cnt;
      pulse_start();
      collect(2, 4, -1);
      check_finish();

      // Reset during word 5 presentation, then restart
      sel_base = sel_cnt;
      pulse_start();
      collect(-1, -1, 5);
      rst = 1'b1;
      #1;
      chk("arst_sel", 32'(pe_mem_sel), 32'd0);
      chk("arst_addr", 32'(pe_addr), 32'd0);
      chk("arst_data", out_data, 32'd0);
      chk("arst_pe", 32'(out_pe), 32'd0);
      chk("arst_oaddr", 32'(out_addr), 32'd0);
      chk("arst_last", 32'(out_last), 32'd0);
      chk("arst_stb", 32'(out_stb), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      sel_base = sel_cnt;
      pulse_start();
      collect(-1, -1, -1);
      check_finish();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
